// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter handing one byte at a time from four requesters
// to a UART transmitter. Define UART_ARB_LOCK_EN to let the owner hold its grant.
module uart_tx_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_lock,
  input  logic        tx_busy,
  output logic [3:0]  ack,
  output logic [3:0]  grant,
  output logic [7:0]  tx_data,
  output logic        tx_latch,
  output logic        arb_busy
);

  // state      | meaning
  // IDLE       | no transfer; arbitrate once tx_busy=0
  // LATCH      | tx_latch strobe for the granted byte
  // WAIT_START | wait up to 4 cycles for tx_busy, then re-strobe
  // WAIT_DONE  | byte accepted; wait for tx_busy to fall
  typedef enum logic [1:0] {IDLE, LATCH, WAIT_START, WAIT_DONE} state_t;

  localparam logic [1:0] RETRY_LOAD = 2'd3;

  state_t     state_q;
  logic [3:0] ack_q, grant_q;
  logic [7:0] tx_data_q;
  logic       tx_latch_q, arb_busy_q;
  logic [1:0] owner_q, last_q, retry_q;

  logic [3:0] elig;
  logic       release_hold, keep_grant;
  logic       win_found;
  logic [1:0] win_idx, cand;

`ifdef UART_ARB_LOCK_EN
  logic held;
  // a retained grant lives only in IDLE; it narrows eligibility to the owner
  assign held         = (state_q == IDLE) && (grant_q != 4'b0000);
  assign elig         = held ? (req & grant_q) : req;
  assign release_hold = held && !req_lock[owner_q];
  assign keep_grant   = req_lock[owner_q];
`else
  logic unused_lock;
  assign unused_lock  = ^req_lock;
  assign elig         = req;
  assign release_hold = 1'b0;
  assign keep_grant   = 1'b0;
`endif

  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ack_q      <= 4'b0000;
      grant_q    <= 4'b0000;
      tx_data_q  <= 8'h00;
      tx_latch_q <= 1'b0;
      arb_busy_q <= 1'b0;
      owner_q    <= 2'd0;
      last_q     <= 2'd3;
      retry_q    <= 2'd0;
    end else begin
      ack_q      <= 4'b0000;
      tx_latch_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (release_hold) begin
            grant_q <= 4'b0000;
          end else if (!tx_busy && win_found) begin
            owner_q    <= win_idx;
            grant_q    <= 4'b0001 << win_idx;
            tx_data_q  <= req_data[{win_idx, 3'b000} +: 8];
            tx_latch_q <= 1'b1;
            arb_busy_q <= 1'b1;
            state_q    <= LATCH;
          end
        end
        LATCH: begin
          retry_q <= RETRY_LOAD;
          state_q <= WAIT_START;
        end
        WAIT_START: begin
          if (tx_busy) begin
            ack_q   <= 4'b0001 << owner_q;
            last_q  <= owner_q;
            state_q <= WAIT_DONE;
          end else if (retry_q == 2'd0) begin
            tx_latch_q <= 1'b1;
            state_q    <= LATCH;
          end else begin
            retry_q <= retry_q - 2'd1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            arb_busy_q <= 1'b0;
            state_q    <= IDLE;
            if (!keep_grant) grant_q <= 4'b0000;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack      = ack_q;
  assign grant    = grant_q;
  assign tx_data  = tx_data_q;
  assign tx_latch = tx_latch_q;
  assign arb_busy = arb_busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed vectors, multi-cycle sequences and
// randomized traffic checked against a transaction-level reference model.
module tb_uart_tx_arbiter;

`ifdef UART_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_lock;
  logic        tx_busy;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic [7:0]  tx_data;
  logic        tx_latch;
  logic        arb_busy;

  uart_tx_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_lock(req_lock),
    .tx_busy(tx_busy), .ack(ack), .grant(grant), .tx_data(tx_data),
    .tx_latch(tx_latch), .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: phase 0 idle, 1 strobe, 2 awaiting start, 3 sending
  int         m_phase, m_owner, m_last, m_wait;
  bit         m_hold;
  logic [3:0] e_ack, e_grant;
  logic [7:0] e_data;
  logic       e_latch, e_busy;

  bit auto_tx;
  int tx_left;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic [3:0] rq, input logic [31:0] rd,
                            input logic [3:0] rl, input logic tb);
    bit found;
    int win;
    e_ack   = 4'h0;
    e_latch = 1'b0;
    if (r) begin
      m_phase = 0; m_last = 3; m_hold = 0; m_owner = 0; m_wait = 0;
      e_grant = 4'h0; e_data = 8'h00;
    end else begin
      case (m_phase)
        0: begin
          if (LOCK && m_hold && !rl[m_owner]) begin
            m_hold  = 0;
            e_grant = 4'h0;
          end else if (!tb) begin
            found = 0; win = 0;
            for (int k = 1; k <= 4; k++) begin
              int c;
              c = (m_last + k) % 4;
              if (!found && rq[c] && (!m_hold || c == m_owner)) begin
                found = 1; win = c;
              end
            end
            if (found) begin
              m_owner = win;
              e_grant = 4'(1 << win);
              e_data  = rd[8*win +: 8];
              e_latch = 1'b1;
              m_phase = 1;
            end
          end
        end
        1: begin m_phase = 2; m_wait = 0; end
        2: begin
          if (tb) begin
            e_ack   = 4'(1 << m_owner);
            m_last  = m_owner;
            m_phase = 3;
          end else begin
            m_wait++;
            if (m_wait == 4) begin m_phase = 1; e_latch = 1'b1; end
          end
        end
        default: begin
          if (!tb) begin
            m_phase = 0;
            if (LOCK && rl[m_owner]) m_hold = 1;
            else e_grant = 4'h0;
          end
        end
      endcase
    end
    e_busy = (m_phase != 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(rst, req, req_data, req_lock, tx_busy);
    #1;
    chk("model", {ack, grant, tx_data, tx_latch, arb_busy},
        {e_ack, e_grant, e_data, e_latch, e_busy});
    chk("ack_onehot", 32'($countones(ack) <= 1), 32'd1);
    chk("ack_granted", 32'(ack & ~grant), 32'd0);
    if (auto_tx) begin
      if (tx_latch) tx_left = 3;
      tx_busy = (tx_left > 0);
      if (tx_left > 0) tx_left--;
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       busy;
    logic [3:0] ack;
    logic [3:0] grant;
    logic       latch;
    logic       abusy;
    logic [7:0] data;
  } vec_t;

  vec_t vt[7];
  logic [7:0] got[$];
  int owners[$];
  int ackcnt[4];
  int exp_own[4];

  initial begin
    vt[0] = '{1'b1, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00};
    vt[1] = '{1'b0, 4'h4, 1'b0, 4'h0, 4'h4, 1'b1, 1'b1, 8'h55};
    vt[2] = '{1'b0, 4'h4, 1'b0, 4'h0, 4'h4, 1'b0, 1'b1, 8'h55};
    vt[3] = '{1'b0, 4'h4, 1'b1, 4'h4, 4'h4, 1'b0, 1'b1, 8'h55};
    vt[4] = '{1'b0, 4'h0, 1'b1, 4'h0, 4'h4, 1'b0, 1'b1, 8'h55};
    vt[5] = '{1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h55};
    vt[6] = '{1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h55};

    rst = 1'b1; req = 4'h0; req_data = 32'h0055_0000; req_lock = 4'h0; tx_busy = 1'b0;
    auto_tx = 0; tx_left = 0;

    // single requester 2, byte 0x55
    for (int i = 0; i < 7; i++) begin
      rst = vt[i].rst; req = vt[i].req; tx_busy = vt[i].busy;
      tick();
      chk($sformatf("vec%0d", i), {ack, grant, tx_latch, arb_busy, tx_data},
          {vt[i].ack, vt[i].grant, vt[i].latch, vt[i].abusy, vt[i].data});
    end

    // transmitter never starts: re-strobe every 5 cycles, then one ack
    req = 4'b0010; req_data = 32'h0000_3C00; tx_busy = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("retry_latch%0d", i), {tx_latch, ack, grant, tx_data},
          {(i % 5 == 0), 4'h0, 4'b0010, 8'h3C});
    end
    tx_busy = 1'b1;
    tick();
    chk("retry_ack", ack, 4'b0010);
    req = 4'h0;
    tick();
    chk("retry_ack_once", ack, 4'h0);
    tx_busy = 1'b0;
    tick();
    chk("retry_idle", {arb_busy, grant}, 5'h00);

    // reset during WAIT_DONE with transmitter busy
    req = 4'b0010; req_data = 32'h0000_7700;
    tick();
    tx_busy = 1'b1;
    tick();
    tick();
    chk("pre_rst_ack", ack, 4'b0010);
    rst = 1'b1;
    tick();
    chk("rst_outputs", {ack, grant, tx_latch, tx_data, arb_busy}, 18'h0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_hold%0d", i), {tx_latch, arb_busy}, 2'b00);
    end
    tx_busy = 1'b0;
    tick();
    chk("rst_resume", {tx_latch, grant, tx_data}, {1'b1, 4'b0010, 8'h77});
    tx_busy = 1'b1;
    tick();
    tick();
    chk("rst_resume_ack", ack, 4'b0010);
    req = 4'h0; tx_busy = 1'b0;
    tick();
    tick();

    // all four requesting, transmitter busy from the cycle after each latch
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'hF; req_data = 32'hA3A2_A1A0; auto_tx = 1; tx_left = 0;
    for (int j = 0; j < 4; j++) ackcnt[j] = 0;
    for (int c = 0; c < 80 && (ackcnt[0] + ackcnt[1] + ackcnt[2] + ackcnt[3]) < 4; c++) begin
      tick();
      if (tx_latch) got.push_back(tx_data);
      for (int j = 0; j < 4; j++) if (ack[j]) begin ackcnt[j]++; req[j] = 1'b0; end
    end
    for (int c = 0; c < 10; c++) tick();
    chk("rr_count", got.size(), 4);
    for (int j = 0; j < 4 && j < got.size(); j++)
      chk($sformatf("rr_byte%0d", j), got[j], 8'hA0 + 8'(j));
    for (int j = 0; j < 4; j++) chk($sformatf("rr_ack%0d", j), ackcnt[j], 1);

    // requesters 0 and 1 with lock on requester 0, lock dropped after 3 bytes
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b0011; req_lock = 4'b0001; req_data = 32'h0000_2211; tx_left = 0;
    for (int c = 0; c < 120 && owners.size() < 4; c++) begin
      tick();
      if (tx_latch) begin
        for (int j = 0; j < 4; j++) if (grant[j]) owners.push_back(j);
        if (owners.size() == 3) req_lock = 4'h0;
      end
    end
    exp_own = LOCK ? '{0, 0, 0, 1} : '{0, 1, 0, 1};
    chk("lock_count", owners.size(), 4);
    for (int j = 0; j < 4 && j < owners.size(); j++)
      chk($sformatf("lock_owner%0d", j), owners[j], exp_own[j]);
    req = 4'h0;
    for (int c = 0; c < 10; c++) tick();
    auto_tx = 0;

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) req_lock = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) tx_busy = ~tx_busy;
      req_data = $urandom();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
